// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - window, writeback, branch and issue signal bundle for issue_scheduler
interface issue_scheduler_if #(
    parameter int NUM_ENTRIES = 4
);
    logic [NUM_ENTRIES-1:0]         win_vld;
    logic [4*NUM_ENTRIES-1:0]       win_des;
    logic [4*NUM_ENTRIES-1:0]       win_s1;
    logic [4*NUM_ENTRIES-1:0]       win_s2;
    logic [4*NUM_ENTRIES-1:0]       win_op;
    logic                           ex_ready;
    logic                           wb_vld0;
    logic                           wb_vld1;
    logic [3:0]                     wb_reg0;
    logic [3:0]                     wb_reg1;
    logic                           br_resolve;
    logic                           br_mispredict;
    logic                           iss_vld0;
    logic                           iss_vld1;
    logic [$clog2(NUM_ENTRIES)-1:0] iss_idx0;
    logic [$clog2(NUM_ENTRIES)-1:0] iss_idx1;
    logic [NUM_ENTRIES-1:0]         win_pop;
    logic                           flush;
    logic                           stall;
    logic [15:0]                    busy_vec;

    modport master (
        output win_vld, win_des, win_s1, win_s2, win_op, ex_ready,
               wb_vld0, wb_vld1, wb_reg0, wb_reg1, br_resolve, br_mispredict,
        input  iss_vld0, iss_vld1, iss_idx0, iss_idx1, win_pop, flush, stall, busy_vec
    );

    modport slave (
        input  win_vld, win_des, win_s1, win_s2, win_op, ex_ready,
               wb_vld0, wb_vld1, wb_reg0, wb_reg1, br_resolve, br_mispredict,
        output iss_vld0, iss_vld1, iss_idx0, iss_idx1, win_pop, flush, stall, busy_vec
    );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-slot issue select with busy scoreboard and branch hold (dual issue under ISSUE_DUAL_EN)
module issue_scheduler #(
    parameter int         NUM_ENTRIES = 4,
    parameter logic [3:0] BR_OP       = 4'hE
) (
    input  logic             clk,
    input  logic             rst,
    issue_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            busy;
    logic [15:0]            busy_nxt;
    logic [3:0]             des [NUM_ENTRIES];
    logic [3:0]             s1  [NUM_ENTRIES];
    logic [3:0]             s2  [NUM_ENTRIES];
    logic [3:0]             op  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ready;
    logic [NUM_ENTRIES-1:0] haz [NUM_ENTRIES];
    logic                   sel0;
    logic                   sel1;
    logic [IDX_W-1:0]       idx0;
    logic [IDX_W-1:0]       idx1;
    logic                   issue_en;
    logic                   iss0;
    logic                   iss1;
    logic [NUM_ENTRIES-1:0] pop;

    function automatic logic reg_busy(input logic [15:0] b, input logic [3:0] r);
        return (r != 4'd0) && b[r];
    endfunction

    function automatic logic [NUM_ENTRIES-1:0] older_mask(input int i);
        return NUM_ENTRIES'((1 << i) - 1);
    endfunction

    // Unpack window fields; haz[i][j] flags valid entry j writing a register entry i touches
    always_comb begin
        des   = '{default: '0};
        s1    = '{default: '0};
        s2    = '{default: '0};
        op    = '{default: '0};
        haz   = '{default: '0};
        ready = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            des[i]   = bus.win_des[4*i +: 4];
            s1[i]    = bus.win_s1[4*i +: 4];
            s2[i]    = bus.win_s2[4*i +: 4];
            op[i]    = bus.win_op[4*i +: 4];
            ready[i] = bus.win_vld[i] && !reg_busy(busy, s1[i]) &&
                       !reg_busy(busy, s2[i]) && !reg_busy(busy, des[i]);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                haz[i][j] = bus.win_vld[j] && (des[j] != 4'd0) &&
                            ((des[j] == s1[i]) || (des[j] == s2[i]) || (des[j] == des[i]));
            end
        end
    end

    // Slot 0: oldest ready entry that no older (necessarily unissued) entry writes into
    always_comb begin
        sel0 = 1'b0;
        idx0 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!sel0 && ready[i] && ((haz[i] & older_mask(i)) == '0)) begin
                sel0 = 1'b1;
                idx0 = IDX_W'(i);
            end
        end
    end

`ifdef ISSUE_DUAL_EN
    // Slot 1: next ready entry above slot 0, independent of slot 0 and of other older unissued writers
    always_comb begin
        sel1 = 1'b0;
        idx1 = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (!sel1 && sel0 && (k > int'(idx0)) && ready[k] &&
                ((haz[k] & older_mask(k) & ~(NUM_ENTRIES'(1) << idx0)) == '0) &&
                ((s1[k] == 4'd0) || (s1[k] != des[idx0])) &&
                ((s2[k] == 4'd0) || (s2[k] != des[idx0])) &&
                (des[k] != des[idx0]) &&
                (op[idx0] != BR_OP) && (op[k] != BR_OP)) begin
                sel1 = 1'b1;
                idx1 = IDX_W'(k);
            end
        end
    end
`else
    assign sel1 = 1'b0;
    assign idx1 = '0;
`endif

    assign issue_en = !rst && (state == RUN) && bus.ex_ready;
    assign iss0     = issue_en && sel0;
    assign iss1     = iss0 && sel1;

    // Pop mask is the union of the issued slot indices
    always_comb begin
        pop = '0;
        if (iss0) pop[idx0] = 1'b1;
        if (iss1) pop[idx1] = 1'b1;
    end

    assign bus.iss_vld0 = iss0;
    assign bus.iss_vld1 = iss1;
    assign bus.iss_idx0 = iss0 ? idx0 : '0;
    assign bus.iss_idx1 = iss1 ? idx1 : '0;
    assign bus.win_pop  = pop;
    assign bus.flush    = !rst && (state == FLUSH);
    assign bus.stall    = !rst && (|bus.win_vld) && !iss0;
    assign bus.busy_vec = busy;

    // Scoreboard next value: writebacks clear first so a same-cycle issue set wins
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_vld0) busy_nxt[bus.wb_reg0] = 1'b0;
        if (bus.wb_vld1) busy_nxt[bus.wb_reg1] = 1'b0;
        if (iss0) busy_nxt[des[idx0]] = 1'b1;
        if (iss1) busy_nxt[des[idx1]] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Branch hold FSM: wait for resolution after a branch issues, flush one cycle on mispredict
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (iss0 && (op[idx0] == BR_OP)) state_nxt = BR_WAIT;
            BR_WAIT: if (bus.br_resolve) state_nxt = bus.br_mispredict ? FLUSH : RUN;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // State and scoreboard registers; flush keeps the scoreboard since writebacks are still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler (dual slot when ISSUE_DUAL_EN is defined)
module tb_issue_scheduler;
`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [3:0] BR = 4'hE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_scheduler_if #(.NUM_ENTRIES(4)) bus ();
    issue_scheduler #(.NUM_ENTRIES(4), .BR_OP(4'hE)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        v0;
        logic [1:0]  i0;
        logic        v1;
        logic [1:0]  i1;
        logic [3:0]  pop;
        logic        flush;
        logic        stall;
        logic [15:0] busy;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        cur;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_busy  = '0;
    int          m_state = 0;
    bit          w_v[4];
    logic [3:0]  w_d[4];
    logic [3:0]  w_a[4];
    logic [3:0]  w_b[4];
    logic [3:0]  w_o[4];
    logic        ex_ready, wb_vld0, wb_vld1, br_resolve, br_mis;
    logic [3:0]  wb_reg0, wb_reg1;

    function automatic bit is_busy(logic [3:0] r);
        return (r != 4'd0) && m_busy[r];
    endfunction

    function automatic bit writer_hits(int j, int i);
        return w_v[j] && (w_d[j] != 4'd0) &&
               (w_d[j] == w_a[i] || w_d[j] == w_b[i] || w_d[j] == w_d[i]);
    endfunction

    function automatic bit can_go(int i, int skip);
        if (!w_v[i] || is_busy(w_a[i]) || is_busy(w_b[i]) || is_busy(w_d[i])) return 1'b0;
        for (int j = 0; j < i; j++)
            if (j != skip && writer_hits(j, i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic obs_t predict();
        obs_t e;
        int   s0 = -1;
        int   s1 = -1;
        e      = '0;
        e.busy = m_busy;
        if (rst) return e;
        e.flush = (m_state == 2);
        if (m_state == 0 && ex_ready) begin
            for (int i = 0; i < 4; i++)
                if (s0 < 0 && can_go(i, -1)) s0 = i;
            if (DUAL && s0 >= 0)
                for (int k = s0 + 1; k < 4; k++)
                    if (s1 < 0 && can_go(k, s0) &&
                        (w_a[k] == 0 || w_a[k] != w_d[s0]) &&
                        (w_b[k] == 0 || w_b[k] != w_d[s0]) &&
                        w_d[k] != w_d[s0] && w_o[s0] != BR && w_o[k] != BR)
                        s1 = k;
        end
        if (s0 >= 0) begin e.v0 = 1'b1; e.i0 = 2'(s0); e.pop[s0] = 1'b1; end
        if (s1 >= 0) begin e.v1 = 1'b1; e.i1 = 2'(s1); e.pop[s1] = 1'b1; end
        e.stall = (w_v[0] || w_v[1] || w_v[2] || w_v[3]) && !e.v0;
        return e;
    endfunction

    task automatic model_update();
        logic [15:0] nb;
        int          n = 0;
        bit          nv[4];
        logic [3:0]  nd[4], na[4], nbb[4], no[4];
        if (rst) begin
            m_busy  = '0;
            m_state = 0;
            return;
        end
        nb = m_busy;
        if (wb_vld0) nb[wb_reg0] = 1'b0;
        if (wb_vld1) nb[wb_reg1] = 1'b0;
        if (cur.v0) nb[w_d[cur.i0]] = 1'b1;
        if (cur.v1) nb[w_d[cur.i1]] = 1'b1;
        nb[0] = 1'b0;
        case (m_state)
            0:       if (cur.v0 && w_o[cur.i0] == BR) m_state = 1;
            1:       if (br_resolve) m_state = br_mis ? 2 : 0;
            default: m_state = 0;
        endcase
        m_busy = nb;
        for (int i = 0; i < 4; i++) begin
            nv[i] = 1'b0; nd[i] = '0; na[i] = '0; nbb[i] = '0; no[i] = '0;
        end
        for (int i = 0; i < 4; i++)
            if (w_v[i] && !cur.pop[i]) begin
                nv[n] = 1'b1; nd[n] = w_d[i]; na[n] = w_a[i]; nbb[n] = w_b[i]; no[n] = w_o[i];
                n++;
            end
        for (int i = 0; i < 4; i++) begin
            w_v[i] = nv[i]; w_d[i] = nd[i]; w_a[i] = na[i]; w_b[i] = nbb[i]; w_o[i] = no[i];
        end
    endtask

    task automatic drive();
        logic [3:0]  v;
        logic [15:0] d, a, b, o;
        for (int i = 0; i < 4; i++) begin
            v[i] = w_v[i]; d[4*i +: 4] = w_d[i]; a[4*i +: 4] = w_a[i];
            b[4*i +: 4] = w_b[i]; o[4*i +: 4] = w_o[i];
        end
        bus.win_vld = v; bus.win_des = d; bus.win_s1 = a; bus.win_s2 = b; bus.win_op = o;
        bus.ex_ready = ex_ready; bus.wb_vld0 = wb_vld0; bus.wb_vld1 = wb_vld1;
        bus.wb_reg0 = wb_reg0; bus.wb_reg1 = wb_reg1;
        bus.br_resolve = br_resolve; bus.br_mispredict = br_mis;
    endtask

    task automatic present();
        drive();
        cur = predict();
        exp_q.push_back(cur);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic set_e(int i, logic [3:0] d, logic [3:0] a, logic [3:0] b, logic [3:0] o);
        w_v[i] = 1'b1; w_d[i] = d; w_a[i] = a; w_b[i] = b; w_o[i] = o;
    endtask

    task automatic clear_win();
        for (int i = 0; i < 4; i++) begin
            w_v[i] = 1'b0; w_d[i] = '0; w_a[i] = '0; w_b[i] = '0; w_o[i] = '0;
        end
    endtask

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        clear_win();
        ex_ready = 1'b0; wb_vld0 = 1'b0; wb_vld1 = 1'b0; wb_reg0 = '0; wb_reg1 = '0;
        br_resolve = 1'b0; br_mis = 1'b0;
        rst = 1'b1;
        present();
        advance();
        rst = 1'b0;
        ex_ready = 1'b1;
    endtask

    // Monitor: compare every presented cycle against the queued model prediction
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.iss_vld0, bus.iss_vld0 ? bus.iss_idx0 : 2'b00,
                     bus.iss_vld1, bus.iss_vld1 ? bus.iss_idx1 : 2'b00,
                     bus.win_pop, bus.flush, bus.stall, bus.busy_vec};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL obs t=%0t act=%h exp=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        clear_win();
        ex_ready = 1'b0; wb_vld0 = 1'b0; wb_vld1 = 1'b0; wb_reg0 = '0; wb_reg1 = '0;
        br_resolve = 1'b0; br_mis = 1'b0;
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;

        do_reset();
        present();
        chk("reset_busy", bus.busy_vec, 16'h0000);
        chk("reset_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        chk("reset_flush", {15'b0, bus.flush}, 16'd0);
        advance();

        // Independent pair
        do_reset();
        set_e(0, 4'd1, 4'd2, 4'd3, 4'd0);
        set_e(1, 4'd4, 4'd5, 4'd6, 4'd0);
        present();
        chk("pair_vld0", {15'b0, bus.iss_vld0}, 16'd1);
        chk("pair_idx0", {14'b0, bus.iss_idx0}, 16'd0);
        chk("pair_vld1", {15'b0, bus.iss_vld1}, DUAL ? 16'd1 : 16'd0);
        chk("pair_idx1", {14'b0, bus.iss_idx1}, DUAL ? 16'd1 : 16'd0);
        chk("pair_pop", {12'b0, bus.win_pop}, DUAL ? 16'h3 : 16'h1);
        advance();
        clear_win();
        present();
        chk("pair_busy", bus.busy_vec, DUAL ? 16'h0012 : 16'h0002);
        advance();

        // RAW inside the pair, then wakeup by writeback
        do_reset();
        set_e(0, 4'd1, 4'd2, 4'd3, 4'd0);
        set_e(1, 4'd5, 4'd1, 4'd6, 4'd0);
        present();
        chk("raw_vld1", {15'b0, bus.iss_vld1}, 16'd0);
        chk("raw_pop", {12'b0, bus.win_pop}, 16'h1);
        advance();
        present();
        chk("raw_wait_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        chk("raw_wait_stall", {15'b0, bus.stall}, 16'd1);
        advance();
        wb_vld0 = 1'b1; wb_reg0 = 4'd1;
        present();
        chk("raw_wb_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        advance();
        wb_vld0 = 1'b0;
        present();
        chk("raw_wake_vld0", {15'b0, bus.iss_vld0}, 16'd1);
        chk("raw_wake_idx0", {14'b0, bus.iss_idx0}, 16'd0);
        advance();

        // Older unissued writer blocks a younger reader
        do_reset();
        set_e(0, 4'd2, 4'd3, 4'd4, 4'd0);
        present();
        advance();
        set_e(0, 4'd7, 4'd2, 4'd3, 4'd0);
        set_e(1, 4'd8, 4'd7, 4'd9, 4'd0);
        present();
        chk("older_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        chk("older_stall", {15'b0, bus.stall}, 16'd1);
        advance();

        // Branch, wait, mispredict flush, resume
        do_reset();
        set_e(0, 4'd10, 4'd1, 4'd2, BR);
        set_e(1, 4'd3, 4'd4, 4'd5, 4'd0);
        present();
        chk("br_vld0", {15'b0, bus.iss_vld0}, 16'd1);
        chk("br_vld1", {15'b0, bus.iss_vld1}, 16'd0);
        advance();
        present();
        chk("br_wait_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        advance();
        br_resolve = 1'b1; br_mis = 1'b1;
        present();
        chk("br_res_flush", {15'b0, bus.flush}, 16'd0);
        chk("br_res_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        advance();
        br_resolve = 1'b0; br_mis = 1'b0;
        present();
        chk("br_flush", {15'b0, bus.flush}, 16'd1);
        chk("br_flush_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        advance();
        present();
        chk("br_after_flush", {15'b0, bus.flush}, 16'd0);
        chk("br_resume_vld0", {15'b0, bus.iss_vld0}, 16'd1);
        advance();

        // Same-cycle set and clear of register 3
        do_reset();
        set_e(0, 4'd3, 4'd1, 4'd2, 4'd0);
        wb_vld1 = 1'b1; wb_reg1 = 4'd3;
        present();
        advance();
        wb_vld1 = 1'b0;
        clear_win();
        present();
        chk("setclr_busy3", {15'b0, bus.busy_vec[3]}, 16'd1);
        advance();

        // Reset while in BR_WAIT
        do_reset();
        set_e(0, 4'd9, 4'd1, 4'd2, BR);
        present();
        advance();
        set_e(0, 4'd3, 4'd4, 4'd5, 4'd0);
        present();
        chk("rstw_wait_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        advance();
        rst = 1'b1;
        present();
        chk("rstw_vld0", {15'b0, bus.iss_vld0}, 16'd0);
        chk("rstw_stall", {15'b0, bus.stall}, 16'd0);
        chk("rstw_pop", {12'b0, bus.win_pop}, 16'd0);
        advance();
        rst = 1'b0;
        present();
        chk("rstw_busy", bus.busy_vec, 16'h0000);
        chk("rstw_resume", {15'b0, bus.iss_vld0}, 16'd1);
        advance();

        // Randomized traffic with a compacting window provider
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            ex_ready   = ($urandom_range(0, 3) != 0);
            wb_vld0    = 1'($urandom_range(0, 1));
            wb_reg0    = 4'($urandom_range(1, 15));
            wb_vld1    = 1'($urandom_range(0, 1));
            wb_reg1    = 4'($urandom_range(1, 15));
            br_resolve = ($urandom_range(0, 4) == 0);
            br_mis     = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++)
                if (!w_v[i] && (i == 0 || w_v[i-1]) && $urandom_range(0, 1) == 1)
                    set_e(i, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                          4'($urandom_range(1, 15)),
                          ($urandom_range(0, 9) == 0) ? BR : 4'($urandom_range(0, 13)));
            present();
            advance();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
